bcp_cmd_driver: RTL

- Programmable-logic initiator for the BCP accelerator's register command interface. It replaces CPU register writes with a hardware driver.
- Accepts one command per valid/ready beat from an upstream sequencer, then drives the four command registers and performs the op/acknowledge handshake.
- Watches the accelerator's sticky status and implication outputs and returns a stream of response beats.
- Lets a hardware solver loop issue clause loads, decisions and backtracks without PS involvement.

---
 rtl/bcp_cmd_driver.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bcp_cmd_driver.sv
// rtl/bcp_cmd_driver.sv - hardware initiator for the BCP accelerator register command interface
module bcp_cmd_driver #(
    parameter int CLAUSE_ID_LEN = 7,
    parameter int VAR_ENC_LEN   = 5,
    parameter int ACK_TIMEOUT   = 64,
    parameter int QUIET_TIMEOUT = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [1:0]                   cmd_op_i,
    input  logic [CLAUSE_ID_LEN-1:0]     cmd_clause_id_i,
    input  logic [3*VAR_ENC_LEN-1:0]     cmd_var_id_i,
    input  logic [2:0]                   cmd_pol_i,
    output logic [31:0]                  axi_reg0_o,
    output logic [31:0]                  axi_reg1_o,
    output logic [31:0]                  axi_reg2_o,
    output logic [31:0]                  axi_reg3_o,
    input  logic                         cpu_op_read_i,
    input  logic [31:0]                  status_i,
    input  logic [VAR_ENC_LEN:0]         impl_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [2:0]                   rsp_code_o,
    output logic [VAR_ENC_LEN:0]         rsp_impl_o,
    output logic                         rsp_last_o,
    output logic                         busy_o
);
    localparam int SNAP_W = 32 + VAR_ENC_LEN + 1;
    localparam int TMAX   = (ACK_TIMEOUT > QUIET_TIMEOUT) ? ACK_TIMEOUT : QUIET_TIMEOUT;
    localparam int TW     = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] QUIET_LIM = TW'(QUIET_TIMEOUT - 1);
    localparam logic [TW-1:0] TSAT      = TW'(TMAX);

    localparam logic [1:0] OP_ILLEGAL  = 2'b00;
    localparam logic [1:0] OP_UPDATE   = 2'b01;
    localparam logic [1:0] OP_DECISION = 2'b10;

    localparam logic [2:0] RSP_QUIET   = 3'd0;
    localparam logic [2:0] RSP_CLAUSE  = 3'd1;
    localparam logic [2:0] RSP_BTRACK  = 3'd2;
    localparam logic [2:0] RSP_TIMEOUT = 3'd7;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_RESP, RESP} state_t;

    state_t                     state;
    logic [1:0]                 op_q;
    logic [CLAUSE_ID_LEN-1:0]   clause_q;
    logic [3*VAR_ENC_LEN-1:0]   var_q;
    logic [2:0]                 pol_q;
    logic [SNAP_W-1:0]          snap_q;
    logic [TW-1:0]              timer_q;

    logic [SNAP_W-1:0]          snap_now;
    logic [TW-1:0]              timer_inc;
    logic [CLAUSE_ID_LEN-1:0]   clause_sel;
    logic                       is_update;

    assign snap_now   = {status_i, impl_i};
    assign timer_inc  = (timer_q == TSAT) ? timer_q : timer_q + TW'(1);
    assign is_update  = (op_q == OP_UPDATE);
    assign clause_sel = is_update ? clause_q : '0;

    function automatic logic [31:0] pack_lit(input logic [VAR_ENC_LEN-1:0] v, input logic p);
        return 32'({v, p});
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            op_q        <= '0;
            clause_q    <= '0;
            var_q       <= '0;
            pol_q       <= '0;
            snap_q      <= '0;
            timer_q     <= '0;
            axi_reg0_o  <= '0;
            axi_reg1_o  <= '0;
            axi_reg2_o  <= '0;
            axi_reg3_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_code_o  <= '0;
            rsp_impl_o  <= '0;
            rsp_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        op_q        <= cmd_op_i;
                        clause_q    <= cmd_clause_id_i;
                        var_q       <= cmd_var_id_i;
                        pol_q       <= cmd_pol_i;
                        snap_q      <= snap_now;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (cmd_op_i == OP_ILLEGAL) begin
                            rsp_valid_o <= 1'b1;
                            rsp_code_o  <= RSP_TIMEOUT;
                            rsp_impl_o  <= '0;
                            rsp_last_o  <= 1'b1;
                            state       <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Only updates carry a clause id and the two extra literals.
                    axi_reg0_o <= 32'({clause_sel, op_q});
                    axi_reg1_o <= pack_lit(var_q[0 +: VAR_ENC_LEN], pol_q[0]);
                    axi_reg2_o <= is_update ? pack_lit(var_q[VAR_ENC_LEN +: VAR_ENC_LEN], pol_q[1]) : '0;
                    axi_reg3_o <= is_update ? pack_lit(var_q[2*VAR_ENC_LEN +: VAR_ENC_LEN], pol_q[2]) : '0;
                    timer_q    <= '0;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (cpu_op_read_i) begin
                        axi_reg0_o[1:0] <= 2'b00;
                        timer_q         <= '0;
                        state           <= WAIT_RESP;
                    end else if (timer_q == ACK_LIM) begin
                        axi_reg0_o[1:0] <= 2'b00;
                        rsp_valid_o     <= 1'b1;
                        rsp_code_o      <= RSP_TIMEOUT;
                        rsp_impl_o      <= '0;
                        rsp_last_o      <= 1'b1;
                        state           <= RESP;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                WAIT_RESP: begin
                    if (op_q == OP_DECISION) begin
                        // Every change of status or implication becomes one beat.
                        if (snap_now != snap_q) begin
                            snap_q      <= snap_now;
                            timer_q     <= '0;
                            rsp_valid_o <= 1'b1;
                            rsp_code_o  <= status_i[2:0];
                            rsp_impl_o  <= impl_i;
                            rsp_last_o  <= (status_i[2:0] == 3'd4) || (status_i[2:0] == 3'd5);
                            state       <= RESP;
                        end else if (timer_q == QUIET_LIM) begin
                            timer_q     <= '0;
                            rsp_valid_o <= 1'b1;
                            rsp_code_o  <= RSP_QUIET;
                            rsp_impl_o  <= '0;
                            rsp_last_o  <= 1'b1;
                            state       <= RESP;
                        end else begin
                            timer_q <= timer_inc;
                        end
                    end else if (timer_q == TW'(1)) begin
                        rsp_valid_o <= 1'b1;
                        rsp_code_o  <= is_update ? RSP_CLAUSE : RSP_BTRACK;
                        rsp_impl_o  <= '0;
                        rsp_last_o  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_code_o  <= '0;
                        rsp_impl_o  <= '0;
                        rsp_last_o  <= 1'b0;
                        if (rsp_last_o) begin
                            busy_o      <= 1'b0;
                            cmd_ready_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
